// File: rtl/mc_ctrl_pkg.sv
// Shared types, opcode/funct values and datapath select encodings for the
// handshaking multicycle MIPS controller.
package mc_ctrl_pkg;

  typedef logic [5:0] opcode_t;
  typedef logic [1:0] sel_t;
  typedef logic [1:0] aluop_t;
  typedef logic [2:0] alucontrol_t;

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr, StRtEx, StRtWb,
    StBeqEx, StBneEx, StIEx, StIWb, StJEx, StJalEx, StJrEx, StFault
  } state_e;

  localparam aluop_t AluOpAdd   = 2'b00;
  localparam aluop_t AluOpSub   = 2'b01;
  localparam aluop_t AluOpFunct = 2'b10;
  localparam aluop_t AluOpSlt   = 2'b11;

  localparam alucontrol_t AluAdd = 3'b010;
  localparam alucontrol_t AluSub = 3'b110;
  localparam alucontrol_t AluAnd = 3'b000;
  localparam alucontrol_t AluOr  = 3'b001;
  localparam alucontrol_t AluSlt = 3'b111;

  localparam opcode_t OpRtype = 6'b000000;
  localparam opcode_t OpLw    = 6'b100011;
  localparam opcode_t OpSw    = 6'b101011;
  localparam opcode_t OpBeq   = 6'b000100;
  localparam opcode_t OpBne   = 6'b000101;
  localparam opcode_t OpAddi  = 6'b001000;
  localparam opcode_t OpSlti  = 6'b001010;
  localparam opcode_t OpJ     = 6'b000010;
  localparam opcode_t OpJal   = 6'b000011;

  localparam opcode_t FnAdd = 6'b100000;
  localparam opcode_t FnSub = 6'b100010;
  localparam opcode_t FnAnd = 6'b100100;
  localparam opcode_t FnOr  = 6'b100101;
  localparam opcode_t FnSlt = 6'b101010;
  localparam opcode_t FnJr  = 6'b001000;

  localparam sel_t MemtoregAluOut = 2'b00;
  localparam sel_t MemtoregData   = 2'b01;
  localparam sel_t MemtoregPc     = 2'b10;

  localparam sel_t RegdstRt = 2'b00;
  localparam sel_t RegdstRd = 2'b01;
  localparam sel_t Regdst31 = 2'b10;

  localparam sel_t SrcbB     = 2'b00;
  localparam sel_t SrcbFour  = 2'b01;
  localparam sel_t SrcbImm   = 2'b10;
  localparam sel_t SrcbImmSh = 2'b11;

  localparam sel_t PcsrcAlu    = 2'b00;
  localparam sel_t PcsrcAluOut = 2'b01;
  localparam sel_t PcsrcJump   = 2'b10;
  localparam sel_t PcsrcRegA   = 2'b11;

  localparam logic [1:0] FaultNone    = 2'b00;
  localparam logic [1:0] FaultIllegal = 2'b01;
  localparam logic [1:0] FaultTimeout = 2'b10;

  typedef struct packed {
    logic   mem_req;
    logic   pcwrite;
    logic   memwrite;
    logic   irwrite;
    logic   regwrite;
    logic   alusrca;
    logic   branch;
    logic   iord;
    sel_t   memtoreg;
    sel_t   regdst;
    sel_t   alusrcb;
    sel_t   pcsrc;
    aluop_t aluop;
  } ctrl_t;

  // States in which a memory access is outstanding and the watchdog runs.
  function automatic logic is_mem_state(state_e s);
    return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
  endfunction

endpackage

// File: rtl/mc_ctrl_hs_if.sv
// Controller <-> datapath/memory bus: instruction fields and flags in,
// control vector, memory request and fault status out.
interface mc_ctrl_hs_if;
  import mc_ctrl_pkg::*;

  opcode_t     op;
  opcode_t     funct;
  logic        zero;
  logic        mem_ready;
  logic        mem_req;
  logic        pcwrite;
  logic        memwrite;
  logic        irwrite;
  logic        regwrite;
  logic        alusrca;
  logic        branch;
  logic        iord;
  sel_t        memtoreg;
  sel_t        regdst;
  sel_t        alusrcb;
  sel_t        pcsrc;
  alucontrol_t alucontrol;
  logic        fault;
  logic [1:0]  fault_code;

  modport master (
    input  op, funct, zero, mem_ready,
    output mem_req, pcwrite, memwrite, irwrite, regwrite, alusrca, branch, iord,
    output memtoreg, regdst, alusrcb, pcsrc, alucontrol, fault, fault_code
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_req, pcwrite, memwrite, irwrite, regwrite, alusrca, branch, iord,
    input  memtoreg, regdst, alusrcb, pcsrc, alucontrol, fault, fault_code
  );

endinterface

// File: rtl/mc_aludec.sv
// ALU decoder: maps the FSM's aluop and the R-type funct field to alucontrol,
// flagging funct values the core does not implement.
module mc_aludec
  import mc_ctrl_pkg::*;
(
  input  aluop_t      aluop_i,
  input  opcode_t     funct_i,
  output alucontrol_t alucontrol_o,
  output logic        illegal_o
);

  always_comb begin
    alucontrol_o = AluAdd;
    illegal_o    = 1'b0;
    unique case (aluop_i)
      AluOpAdd: alucontrol_o = AluAdd;
      AluOpSub: alucontrol_o = AluSub;
      AluOpSlt: alucontrol_o = AluSlt;
      AluOpFunct: begin
        case (funct_i)
          FnAdd:   alucontrol_o = AluAdd;
          FnSub:   alucontrol_o = AluSub;
          FnAnd:   alucontrol_o = AluAnd;
          FnOr:    alucontrol_o = AluOr;
          FnSlt:   alucontrol_o = AluSlt;
          default: illegal_o = 1'b1;
        endcase
      end
      default: alucontrol_o = AluAdd;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_hs.sv
// Multicycle MIPS control FSM with a mem_req/mem_ready handshake, optional
// extended ISA and a per-access memory-wait watchdog that halts the core.
module mc_ctrl_hs
  import mc_ctrl_pkg::*;
#(
  parameter bit          MEM_HS   = 1'b1,
  parameter bit          EXT_ISA  = 1'b1,
  parameter int unsigned WAIT_MAX = 255
) (
  input logic          clk,
  input logic          reset,
  mc_ctrl_hs_if.master bus_io
);

  localparam int unsigned CntW = $clog2(WAIT_MAX + 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      fault_code_q, fault_code_d;
  ctrl_t           ctrl;
  alucontrol_t     alucontrol;
  logic            alu_illegal;
  logic            rdy;
  logic            waiting;
  logic            illegal;

  assign rdy     = MEM_HS ? bus_io.mem_ready : 1'b1;
  assign waiting = MEM_HS && is_mem_state(state_q) && !rdy;

  mc_aludec u_aludec (
    .aluop_i      (ctrl.aluop),
    .funct_i      (bus_io.funct),
    .alucontrol_o (alucontrol),
    .illegal_o    (alu_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StFetch;
      cnt_q        <= '0;
      fault_code_q <= FaultNone;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fault_code_q <= fault_code_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    fault_code_d = fault_code_q;
    illegal      = 1'b0;
    unique case (state_q)
      StFetch: if (rdy) state_d = StDecode;
      StDecode: begin
        case (bus_io.op)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = (EXT_ISA && bus_io.funct == FnJr) ? StJrEx : StRtEx;
          OpBeq:      state_d = StBeqEx;
          OpJ:        state_d = StJEx;
          OpBne:      if (EXT_ISA) state_d = StBneEx; else illegal = 1'b1;
          OpAddi,
          OpSlti:     if (EXT_ISA) state_d = StIEx; else illegal = 1'b1;
          OpJal:      if (EXT_ISA) state_d = StJalEx; else illegal = 1'b1;
          default:    illegal = 1'b1;
        endcase
      end
      StMemAdr: state_d = (bus_io.op == OpSw) ? StMemWr : StMemRd;
      StMemRd:  if (rdy) state_d = StMemWb;
      StMemWr:  if (rdy) state_d = StFetch;
      StRtEx:   if (alu_illegal) illegal = 1'b1; else state_d = StRtWb;
      StIEx:    state_d = StIWb;
      StMemWb, StRtWb, StIWb, StBeqEx, StBneEx, StJEx, StJalEx, StJrEx: state_d = StFetch;
      StFault:  state_d = StFault;
    endcase

    if (illegal) begin
      state_d      = StFault;
      fault_code_d = FaultIllegal;
    end

    // Counter only survives while the same access keeps waiting.
    if (waiting) begin
      if (cnt_q == CntW'(WAIT_MAX - 1)) begin
        state_d      = StFault;
        fault_code_d = FaultTimeout;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    ctrl = '0;
    unique case (state_q)
      StFetch: begin
        ctrl.mem_req = 1'b1;
        ctrl.alusrcb = SrcbFour;
        ctrl.pcsrc   = PcsrcAlu;
        ctrl.irwrite = rdy;
        ctrl.pcwrite = rdy;
      end
      StDecode: ctrl.alusrcb = SrcbImmSh;
      StMemAdr: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SrcbImm;
      end
      StMemRd: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      StMemWr: begin
        ctrl.mem_req  = 1'b1;
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      StMemWb: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = RegdstRt;
        ctrl.memtoreg = MemtoregData;
      end
      StRtEx: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SrcbB;
        ctrl.aluop   = AluOpFunct;
      end
      StRtWb: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = RegdstRd;
        ctrl.memtoreg = MemtoregAluOut;
      end
      StBeqEx, StBneEx: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = AluOpSub;
        ctrl.pcsrc   = PcsrcAluOut;
        // beq lets the datapath qualify with zero; bne is resolved here.
        ctrl.branch  = (state_q == StBeqEx);
        ctrl.pcwrite = (state_q == StBneEx) && !bus_io.zero;
      end
      StIEx: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SrcbImm;
        ctrl.aluop   = (bus_io.op == OpSlti) ? AluOpSlt : AluOpAdd;
      end
      StIWb: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = RegdstRt;
      end
      StJEx: begin
        ctrl.pcsrc   = PcsrcJump;
        ctrl.pcwrite = 1'b1;
      end
      StJalEx: begin
        ctrl.pcsrc    = PcsrcJump;
        ctrl.pcwrite  = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = Regdst31;
        ctrl.memtoreg = MemtoregPc;
      end
      StJrEx: begin
        ctrl.pcsrc   = PcsrcRegA;
        ctrl.pcwrite = 1'b1;
      end
      StFault: ctrl = '0;
    endcase
  end

  assign bus_io.mem_req    = ctrl.mem_req;
  assign bus_io.pcwrite    = ctrl.pcwrite;
  assign bus_io.memwrite   = ctrl.memwrite;
  assign bus_io.irwrite    = ctrl.irwrite;
  assign bus_io.regwrite   = ctrl.regwrite;
  assign bus_io.alusrca    = ctrl.alusrca;
  assign bus_io.branch     = ctrl.branch;
  assign bus_io.iord       = ctrl.iord;
  assign bus_io.memtoreg   = ctrl.memtoreg;
  assign bus_io.regdst     = ctrl.regdst;
  assign bus_io.alusrcb    = ctrl.alusrcb;
  assign bus_io.pcsrc      = ctrl.pcsrc;
  assign bus_io.alucontrol = alucontrol;
  assign bus_io.fault      = (state_q == StFault);
  assign bus_io.fault_code = fault_code_q;

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// Directed bench for mc_ctrl_hs: per-cycle expected control vectors are queued
// as each instruction is set up, then popped and checked cycle by cycle.
module tb_mc_ctrl_hs;

  typedef struct packed {
    logic       mem_req, pcwrite, memwrite, irwrite, regwrite, alusrca, branch, iord;
    logic [1:0] memtoreg, regdst, alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       fault;
    logic [1:0] fault_code;
  } vec_t;

  typedef struct {
    int    d;
    logic  rdy;
    vec_t  exp;
    string tag;
  } sb_t;

  localparam int SFetch = 0, SDecode = 1, SMemAdr = 2, SMemRd = 3, SMemWb = 4, SMemWr = 5;
  localparam int SRtEx = 6, SRtWb = 7, SBeqEx = 8, SBneEx = 9, SIEx = 10, SIWb = 11;
  localparam int SJEx = 12, SJalEx = 13, SJrEx = 14, SFault = 15;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    checks = 0;
  int    fails = 0;
  string cur = "init";
  sb_t   sb[$];
  vec_t  obs_a, obs_b, obs_c;

  mc_ctrl_hs_if if_a ();
  mc_ctrl_hs_if if_b ();
  mc_ctrl_hs_if if_c ();

  always #5 clk = ~clk;

  mc_ctrl_hs #(.MEM_HS(1'b1), .EXT_ISA(1'b1), .WAIT_MAX(255)) u_a (
    .clk(clk), .reset(rst), .bus_io(if_a)
  );
  mc_ctrl_hs #(.MEM_HS(1'b1), .EXT_ISA(1'b0), .WAIT_MAX(4)) u_b (
    .clk(clk), .reset(rst), .bus_io(if_b)
  );
  mc_ctrl_hs #(.MEM_HS(1'b0), .EXT_ISA(1'b1), .WAIT_MAX(255)) u_c (
    .clk(clk), .reset(rst), .bus_io(if_c)
  );

  assign obs_a = {if_a.mem_req, if_a.pcwrite, if_a.memwrite, if_a.irwrite, if_a.regwrite,
                  if_a.alusrca, if_a.branch, if_a.iord, if_a.memtoreg, if_a.regdst,
                  if_a.alusrcb, if_a.pcsrc, if_a.alucontrol, if_a.fault, if_a.fault_code};
  assign obs_b = {if_b.mem_req, if_b.pcwrite, if_b.memwrite, if_b.irwrite, if_b.regwrite,
                  if_b.alusrca, if_b.branch, if_b.iord, if_b.memtoreg, if_b.regdst,
                  if_b.alusrcb, if_b.pcsrc, if_b.alucontrol, if_b.fault, if_b.fault_code};
  assign obs_c = {if_c.mem_req, if_c.pcwrite, if_c.memwrite, if_c.irwrite, if_c.regwrite,
                  if_c.alusrca, if_c.branch, if_c.iord, if_c.memtoreg, if_c.regdst,
                  if_c.alusrcb, if_c.pcsrc, if_c.alucontrol, if_c.fault, if_c.fault_code};

  // x: ready for FETCH, zero for BNEEX, alucontrol for RTEX/IEX, code for FAULT.
  function automatic vec_t mk(input int st, input logic [2:0] x);
    vec_t v;
    v = '0;
    v.alucontrol = 3'b010;
    case (st)
      SFetch:  begin v.mem_req = 1'b1; v.pcwrite = x[0]; v.irwrite = x[0]; v.alusrcb = 2'b01; end
      SDecode: v.alusrcb = 2'b11;
      SMemAdr: begin v.alusrca = 1'b1; v.alusrcb = 2'b10; end
      SMemRd:  begin v.mem_req = 1'b1; v.iord = 1'b1; end
      SMemWr:  begin v.mem_req = 1'b1; v.iord = 1'b1; v.memwrite = 1'b1; end
      SMemWb:  begin v.regwrite = 1'b1; v.memtoreg = 2'b01; end
      SRtEx:   begin v.alusrca = 1'b1; v.alucontrol = x; end
      SRtWb:   begin v.regwrite = 1'b1; v.regdst = 2'b01; end
      SBeqEx:  begin v.alusrca = 1'b1; v.alucontrol = 3'b110; v.pcsrc = 2'b01; v.branch = 1'b1; end
      SBneEx:  begin v.alusrca = 1'b1; v.alucontrol = 3'b110; v.pcsrc = 2'b01; v.pcwrite = !x[0]; end
      SIEx:    begin v.alusrca = 1'b1; v.alusrcb = 2'b10; v.alucontrol = x; end
      SIWb:    v.regwrite = 1'b1;
      SJEx:    begin v.pcsrc = 2'b10; v.pcwrite = 1'b1; end
      SJalEx:  begin
        v.pcsrc = 2'b10; v.pcwrite = 1'b1; v.regwrite = 1'b1; v.regdst = 2'b10; v.memtoreg = 2'b10;
      end
      SJrEx:   begin v.pcsrc = 2'b11; v.pcwrite = 1'b1; end
      SFault:  begin v.fault = 1'b1; v.fault_code = x[1:0]; end
      default: ;
    endcase
    return v;
  endfunction

  task automatic push(input int d, input logic rdy, input int st, input logic [2:0] x);
    sb_t e;
    e.d   = d;
    e.rdy = rdy;
    e.exp = mk(st, x);
    e.tag = $sformatf("%s/st%0d", cur, st);
    sb.push_back(e);
  endtask

  task automatic fetch(input int d, input int nwait);
    for (int i = 0; i < nwait; i++) push(d, 1'b0, SFetch, 3'd0);
    push(d, 1'b1, SFetch, 3'd1);
    push(d, 1'b1, SDecode, 3'd0);
  endtask

  task automatic set_in(input int d, input logic [5:0] op, input logic [5:0] fn, input logic z);
    case (d)
      0:       begin if_a.op = op; if_a.funct = fn; if_a.zero = z; end
      1:       begin if_b.op = op; if_b.funct = fn; if_b.zero = z; end
      default: begin if_c.op = op; if_c.funct = fn; if_c.zero = z; end
    endcase
  endtask

  task automatic drain();
    sb_t  e;
    vec_t o;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge clk);
      case (e.d)
        0:       if_a.mem_ready = e.rdy;
        1:       if_b.mem_ready = e.rdy;
        default: if_c.mem_ready = e.rdy;
      endcase
      #1;
      o = (e.d == 0) ? obs_a : ((e.d == 1) ? obs_b : obs_c);
      checks++;
      assert (o === e.exp) else begin
        fails++;
        $error("FAIL %s: observed %h expected %h", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    if_a.mem_ready = 1'b0;
    if_b.mem_ready = 1'b0;
    if_c.mem_ready = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "time limit");
  end

  initial begin
    for (int d = 0; d < 3; d++) set_in(d, 6'h00, 6'h00, 1'b0);
    if_a.mem_ready = 1'b0;
    if_b.mem_ready = 1'b0;
    if_c.mem_ready = 1'b0;
    do_reset();

    cur = "reset_a";  push(0, 1'b0, SFetch, 3'd0); drain();
    cur = "add";      set_in(0, 6'h00, 6'h20, 1'b0); fetch(0, 0);
    push(0, 1'b1, SRtEx, 3'b010); push(0, 1'b1, SRtWb, 3'd0); drain();
    cur = "lw";       set_in(0, 6'h23, 6'h00, 1'b0); fetch(0, 0);
    push(0, 1'b1, SMemAdr, 3'd0); push(0, 1'b1, SMemRd, 3'd0); push(0, 1'b1, SMemWb, 3'd0); drain();
    cur = "sw";       set_in(0, 6'h2B, 6'h00, 1'b0); fetch(0, 0);
    push(0, 1'b1, SMemAdr, 3'd0); push(0, 1'b1, SMemWr, 3'd0); drain();
    cur = "beq";      set_in(0, 6'h04, 6'h00, 1'b1); fetch(0, 0); push(0, 1'b1, SBeqEx, 3'd0); drain();
    cur = "j";        set_in(0, 6'h02, 6'h00, 1'b0); fetch(0, 0); push(0, 1'b1, SJEx, 3'd0); drain();

    cur = "lw_wait";  set_in(0, 6'h23, 6'h00, 1'b0); fetch(0, 3); push(0, 1'b1, SMemAdr, 3'd0);
    for (int i = 0; i < 3; i++) push(0, 1'b0, SMemRd, 3'd0);
    push(0, 1'b1, SMemRd, 3'd0); push(0, 1'b1, SMemWb, 3'd0); drain();
    cur = "sw_wait";  set_in(0, 6'h2B, 6'h00, 1'b0); fetch(0, 0); push(0, 1'b1, SMemAdr, 3'd0);
    push(0, 1'b0, SMemWr, 3'd0); push(0, 1'b0, SMemWr, 3'd0); push(0, 1'b1, SMemWr, 3'd0);
    push(0, 1'b0, SFetch, 3'd0); drain();

    cur = "bne_nz";   set_in(0, 6'h05, 6'h00, 1'b0); fetch(0, 0); push(0, 1'b1, SBneEx, 3'd0); drain();
    cur = "bne_z";    set_in(0, 6'h05, 6'h00, 1'b1); fetch(0, 0); push(0, 1'b1, SBneEx, 3'd1); drain();
    cur = "jal";      set_in(0, 6'h03, 6'h00, 1'b0); fetch(0, 0); push(0, 1'b1, SJalEx, 3'd0); drain();
    cur = "jr";       set_in(0, 6'h00, 6'h08, 1'b0); fetch(0, 0); push(0, 1'b1, SJrEx, 3'd0); drain();
    cur = "sub";      set_in(0, 6'h00, 6'h22, 1'b0); fetch(0, 0);
    push(0, 1'b1, SRtEx, 3'b110); push(0, 1'b1, SRtWb, 3'd0); drain();
    cur = "or";       set_in(0, 6'h00, 6'h25, 1'b0); fetch(0, 0);
    push(0, 1'b1, SRtEx, 3'b001); push(0, 1'b1, SRtWb, 3'd0); drain();
    cur = "addi";     set_in(0, 6'h08, 6'h00, 1'b0); fetch(0, 0);
    push(0, 1'b1, SIEx, 3'b010); push(0, 1'b1, SIWb, 3'd0); drain();
    cur = "slti";     set_in(0, 6'h0A, 6'h00, 1'b0); fetch(0, 0);
    push(0, 1'b1, SIEx, 3'b111); push(0, 1'b1, SIWb, 3'd0); drain();

    cur = "sw_abort"; set_in(0, 6'h2B, 6'h00, 1'b0); fetch(0, 0);
    push(0, 1'b1, SMemAdr, 3'd0); push(0, 1'b0, SMemWr, 3'd0); drain();
    do_reset();
    push(0, 1'b0, SFetch, 3'd0); drain();

    cur = "illegal";  set_in(0, 6'h3F, 6'h00, 1'b0); fetch(0, 0);
    push(0, 1'b1, SFault, 3'd1); push(0, 1'b1, SFault, 3'd1); drain();
    do_reset();
    cur = "clr_ill";  push(0, 1'b0, SFetch, 3'd0); drain();

    do_reset();
    cur = "b_j_3wait"; set_in(1, 6'h02, 6'h00, 1'b0); fetch(1, 3); push(1, 1'b1, SJEx, 3'd0); drain();
    cur = "b_addi";    set_in(1, 6'h08, 6'h00, 1'b0); fetch(1, 0);
    push(1, 1'b1, SFault, 3'd1); drain();
    do_reset();
    cur = "b_timeout";
    for (int i = 0; i < 4; i++) push(1, 1'b0, SFetch, 3'd0);
    push(1, 1'b1, SFault, 3'd2); push(1, 1'b1, SFault, 3'd2); drain();
    do_reset();
    cur = "b_clr_to";  push(1, 1'b0, SFetch, 3'd0); drain();

    do_reset();
    cur = "c_add";     set_in(2, 6'h00, 6'h20, 1'b0);
    push(2, 1'b0, SFetch, 3'd1); push(2, 1'b0, SDecode, 3'd0);
    push(2, 1'b0, SRtEx, 3'b010); push(2, 1'b0, SRtWb, 3'd0); drain();
    cur = "c_lw";      set_in(2, 6'h23, 6'h00, 1'b0);
    push(2, 1'b0, SFetch, 3'd1); push(2, 1'b0, SDecode, 3'd0); push(2, 1'b0, SMemAdr, 3'd0);
    push(2, 1'b0, SMemRd, 3'd0); push(2, 1'b0, SMemWb, 3'd0); drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
